result_uploader: RTL and testbench
==================================

Name: result_uploader

Overview:
- Sits directly downstream of the matrix-multiply core and consumes the result matrix it leaves in data memory.
- When the core raises its end-of-process flag, the block takes over the data-memory address port and reads the result words one by one.
- It serialises each 16-bit word into two bytes and sends them over a valid/ready byte stream to the UART transmitter.

Parameters:
- MEM_LAT, 1, data-memory read latency in clocks from addr_data change to valid dataout; legal 1..3.
- HI_FIRST, 0, byte order: 0 sends low byte first, 1 sends high byte first.

Ports:
- clock  input  1  system clock, all state on rising edge
- RST  input  1  reset; synchronous, active-high
- done  input  1  end-of-process flag from the core
- res_base  input  8  data-memory address of first result word
- res_len  input  8  number of 16-bit result words; 0 = nothing to send
- mem_sel  output  1  1 = this block drives the data-memory address mux, 0 = core drives it
- addr_data  output  8  data-memory read address
- dataout  input  16  data-memory read data
- tx_data  output  8  byte to UART transmitter
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  UART transmitter can accept a byte
- busy  output  1  upload in progress
- upload_done  output  1  all result bytes accepted

Behaviour:
- Reset (RST=1 at an edge) clears every output to 0 and puts the FSM in IDLE. It overrides all other events.
- Reset mid-upload: tx_valid falls on that same edge and no further bytes are sent. Bytes already accepted are not repeated until the next done.
- States and transitions:
  - IDLE: when done=1, latch res_base into the address counter and res_len into the word counter.
    - If res_len=0, go to FIN.
    - Otherwise go to RD, with mem_sel=1 and busy=1.
  - RD: drive addr_data = current address; wait MEM_LAT clocks, then capture dataout into a 16-bit holding register and go to TX0.
  - TX0: tx_valid=1, tx_data = first byte (low byte if HI_FIRST=0). On an edge with tx_ready=1, go to TX1.
  - TX1: tx_valid=1, tx_data = second byte. On an edge with tx_ready=1:
    - decrement the word counter and increment the address (mod 256; 0xFF wraps to 0x00);
    - if the counter reaches 0, go to FIN, else go to RD.
  - FIN: mem_sel=0, busy=0, upload_done=1. Stay here while done=1. When done=0, go to IDLE and clear upload_done. This prevents a re-trigger while done is held high.
- Handshake rules:
  - A byte transfers only on an edge where tx_valid=1 and tx_ready=1.
  - While waiting for tx_ready, tx_data holds stable and tx_valid stays high. tx_valid never drops without a transfer, except on RST.
  - Back-to-back transfers are allowed: TX0 to TX1 with no bubble.
- Throughput: per word, MEM_LAT clocks of read plus 2 handshake clocks minimum. With MEM_LAT=1 and tx_ready tied high, a word takes 3 clocks.
- addr_data is valid only while mem_sel=1; its value when mem_sel=0 is 0.
- res_base and res_len are sampled only on the IDLE→RD/FIN edge. Later changes are ignored.
- The holding register is refreshed only in RD. A dataout change while in TX0/TX1 has no effect.
- done falling mid-upload is ignored; the upload completes.

Test Plan:
- Basic: MEM_LAT=1, HI_FIRST=0, res_base=0x10, res_len=2, mem[0x10]=0x1234, mem[0x11]=0xABCD, tx_ready=1, pulse done → bytes 0x34,0x12,0xCD,0xAB in order. Then upload_done=1, busy=0, mem_sel=0; 6 clocks from the first RD cycle to FIN.
- Backpressure: same data, tx_ready low for 5 clocks while in TX1 of word 0 → tx_valid stays 1 and tx_data stays 0x12 for all 5 clocks; exactly 4 transfers total, no duplicates.
- Zero length: res_len=0, done=1 → no tx_valid, mem_sel never 1, upload_done=1 on the next edge. Held done=1 for 10 clocks → no restart. done=0 → upload_done=0, back in IDLE.
- Wrap: res_base=0xFF, res_len=2, mem[0xFF]=0x0001, mem[0x00]=0x0002, HI_FIRST=1, MEM_LAT=3 → addr_data sequence 0xFF then 0x00; bytes 0x00,0x01,0x00,0x02.
- Reset mid-operation: res_len=4, assert RST for one clock after the 3rd byte transfer → all outputs 0 on the next edge. With done still 1, a restart begins at res_base and sends the full 8 bytes from the start.

Source files
------------

// File: rtl/result_uploader.sv
// Drains the matrix-multiply result words from data memory once the core signals done,
// and streams each 16-bit word as two bytes over a valid/ready link to the UART transmitter.
module result_uploader #(
   parameter int MEM_LAT  = 1,    // read latency in clocks, 1..3
   parameter bit HI_FIRST = 1'b0
) (
   input  logic        clock,
   input  logic        RST,
   input  logic        done,
   input  logic [7:0]  res_base,
   input  logic [7:0]  res_len,
   output logic        mem_sel,
   output logic [7:0]  addr_data,
   input  logic [15:0] dataout,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic        upload_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_TX0,
      S_TX1,
      S_FIN
   } state_t;

   localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

   state_t      state_q, state_d;
   logic [7:0]  addr_q, addr_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] hold_q, hold_d;
   logic [1:0]  lat_q, lat_d;

   logic [7:0]  first_byte;
   logic [7:0]  second_byte;

   always_ff @(posedge clock) begin
      if (RST) begin
         state_q <= S_IDLE;
         addr_q  <= 8'h00;
         cnt_q   <= 8'h00;
         hold_q  <= 16'h0000;
         lat_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         lat_q   <= lat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      lat_d   = lat_q;
      case (state_q)
         S_IDLE: begin
            if (done) begin
               addr_d  = res_base;
               cnt_d   = res_len;
               lat_d   = 2'd0;
               state_d = (res_len == 8'h00) ? S_FIN : S_RD;
            end
         end
         S_RD: begin
            // The address is held for the whole read; data is taken on the last latency cycle.
            if (lat_q == LAT_LAST) begin
               hold_d  = dataout;
               state_d = S_TX0;
            end else begin
               lat_d = lat_q + 2'd1;
            end
         end
         S_TX0: begin
            if (tx_ready) state_d = S_TX1;
         end
         S_TX1: begin
            if (tx_ready) begin
               cnt_d   = cnt_q - 8'd1;
               addr_d  = addr_q + 8'd1;
               lat_d   = 2'd0;
               state_d = (cnt_q == 8'd1) ? S_FIN : S_RD;
            end
         end
         S_FIN: begin
            // Holding here while done stays high stops a second upload of the same result.
            if (!done) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign first_byte  = HI_FIRST ? hold_q[15:8] : hold_q[7:0];
   assign second_byte = HI_FIRST ? hold_q[7:0]  : hold_q[15:8];

   assign mem_sel     = (state_q == S_RD) || (state_q == S_TX0) || (state_q == S_TX1);
   assign busy        = mem_sel;
   assign addr_data   = mem_sel ? addr_q : 8'h00;
   assign tx_valid    = (state_q == S_TX0) || (state_q == S_TX1);
   assign tx_data     = (state_q == S_TX0) ? first_byte :
                        (state_q == S_TX1) ? second_byte : 8'h00;
   assign upload_done = (state_q == S_FIN);

endmodule

// File: tb/tb_result_uploader.sv
// Scoreboard bench for result_uploader: two instances (MEM_LAT=1/low-first, MEM_LAT=3/high-first)
// share one stimulus stream; expected bytes come from a word-list model of data memory.
module tb_result_uploader;

   logic        clock;
   logic        RST;
   logic        done;
   logic        tx_ready;
   logic [7:0]  res_base;
   logic [7:0]  res_len;
   logic [1:0]  mem_sel;
   logic [1:0]  tx_valid;
   logic [1:0]  busy;
   logic [1:0]  upload_done;
   logic [7:0]  addr_data [2];
   logic [7:0]  tx_data   [2];
   logic [15:0] dataout   [2];
   logic [15:0] mem       [256];

   logic [7:0]  exp_q [2][$];
   int          checks;
   int          errors;
   int          xfer_cnt  [2];
   bit          prev_wait [2];
   logic [7:0]  prev_data [2];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int ML = (g == 0) ? 1 : 3;
      result_uploader #(.MEM_LAT(ML), .HI_FIRST(1'(g))) u_dut (
         .clock       (clock),
         .RST         (RST),
         .done        (done),
         .res_base    (res_base),
         .res_len     (res_len),
         .mem_sel     (mem_sel[g]),
         .addr_data   (addr_data[g]),
         .dataout     (dataout[g]),
         .tx_data     (tx_data[g]),
         .tx_valid    (tx_valid[g]),
         .tx_ready    (tx_ready),
         .busy        (busy[g]),
         .upload_done (upload_done[g])
      );
      if (ML == 1) begin : g_comb
         assign dataout[g] = mem[addr_data[g]];
      end else begin : g_pipe
         logic [15:0] pipe [ML-1];
         always @(posedge clock) begin
            pipe[0] <= mem[addr_data[g]];
            for (int k = 1; k < ML - 1; k++) pipe[k] <= pipe[k-1];
         end
         assign dataout[g] = pipe[ML-2];
      end
   end

   function automatic int ml(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // Model: a word list read from base upward with 8-bit address wrap, two bytes per word.
   task automatic expect_push(input logic [7:0] base, input logic [7:0] len);
      logic [15:0] w;
      for (int k = 0; k < int'(len); k++) begin
         w = mem[8'(int'(base) + k)];
         exp_q[0].push_back(w[7:0]);
         exp_q[0].push_back(w[15:8]);
         exp_q[1].push_back(w[15:8]);
         exp_q[1].push_back(w[7:0]);
      end
   endtask

   // Monitor: pops one expected byte per accepted transfer and checks hold-while-stalled.
   always @(negedge clock) begin
      logic [7:0] e;
      for (int i = 0; i < 2; i++) begin
         if (RST) begin
            prev_wait[i] <= 1'b0;
         end else begin
            if (prev_wait[i]) begin
               chk($sformatf("stall_valid%0d", i), 32'(tx_valid[i]), 32'd1);
               chk($sformatf("stall_data%0d", i), 32'(tx_data[i]), 32'(prev_data[i]));
            end
            if (!mem_sel[i]) chk($sformatf("addr_idle%0d", i), 32'(addr_data[i]), 32'd0);
            if (tx_valid[i] && tx_ready) begin
               if (exp_q[i].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL extra_byte%0d: got %0h expected no transfer", i, tx_data[i]);
               end else begin
                  e = exp_q[i].pop_front();
                  chk($sformatf("byte%0d", i), 32'(tx_data[i]), 32'(e));
               end
               xfer_cnt[i] <= xfer_cnt[i] + 1;
            end
            prev_wait[i] <= tx_valid[i] && !tx_ready;
            prev_data[i] <= tx_data[i];
         end
      end
   end

   task automatic check_zero(input string nm);
      for (int i = 0; i < 2; i++) begin
         chk({nm, "_mem_sel"}, 32'(mem_sel[i]), 32'd0);
         chk({nm, "_addr"}, 32'(addr_data[i]), 32'd0);
         chk({nm, "_tx_valid"}, 32'(tx_valid[i]), 32'd0);
         chk({nm, "_tx_data"}, 32'(tx_data[i]), 32'd0);
         chk({nm, "_busy"}, 32'(busy[i]), 32'd0);
         chk({nm, "_upload_done"}, 32'(upload_done[i]), 32'd0);
      end
   endtask

   task automatic start(input logic [7:0] base, input logic [7:0] len, input bit pulse);
      expect_push(base, len);
      res_base = base;
      res_len  = len;
      done     = 1'b1;
      @(posedge clock); #1;
      res_base = 8'($urandom);
      res_len  = 8'($urandom);
      if (pulse) done = 1'b0;
   endtask

   task automatic wait_finish(input int len, input bit rand_rdy, input bit chk_time);
      bit seen [2];
      int bcyc [2];
      int c;
      seen = '{1'b0, 1'b0};
      bcyc = '{0, 0};
      c = 0;
      while (!(seen[0] && seen[1]) && c < 2000) begin
         if (rand_rdy) tx_ready = 1'($urandom_range(0, 1));
         @(negedge clock);
         for (int i = 0; i < 2; i++) begin
            if (busy[i]) bcyc[i]++;
            if (upload_done[i]) seen[i] = 1'b1;
         end
         @(posedge clock); #1;
         c++;
      end
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("finish%0d", i), 32'(seen[i]), 32'd1);
         if (chk_time) chk($sformatf("busy_cycles%0d", i), 32'(bcyc[i]), 32'(len * (ml(i) + 2)));
      end
      done     = 1'b0;
      tx_ready = 1'b1;
      @(posedge clock); #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("done_clear%0d", i), 32'(upload_done[i]), 32'd0);
         chk($sformatf("busy_clear%0d", i), 32'(busy[i]), 32'd0);
         chk($sformatf("queue_empty%0d", i), 32'(exp_q[i].size()), 32'd0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [7:0] base;
      logic [7:0] len;
      int b0;
      int c;
      bit rr;
      bit pu;
      checks   = 0;
      errors   = 0;
      RST      = 1'b1;
      done     = 1'b0;
      tx_ready = 1'b1;
      res_base = 8'h00;
      res_len  = 8'h00;
      for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
      repeat (2) @(posedge clock);
      #1;
      check_zero("reset");
      RST = 1'b0;
      @(posedge clock); #1;

      // Basic two-word upload, ready tied high
      mem[8'h10] = 16'h1234;
      mem[8'h11] = 16'hABCD;
      start(8'h10, 8'd2, 1'b0);
      chk("basic_addr", 32'(addr_data[0]), 32'h10);
      chk("basic_mem_sel", 32'(mem_sel[0]), 32'd1);
      wait_finish(2, 1'b0, 1'b1);

      // Backpressure: stall five clocks while word 0 second byte is offered
      b0 = xfer_cnt[0];
      start(8'h10, 8'd2, 1'b0);
      c = 0;
      while ((xfer_cnt[0] - b0) < 1 && c < 100) begin
         @(posedge clock); #1;
         c++;
      end
      chk("bp_first_xfer", 32'(xfer_cnt[0] - b0), 32'd1);
      tx_ready = 1'b0;
      repeat (5) begin
         @(negedge clock);
         chk("bp_valid", 32'(tx_valid[0]), 32'd1);
         chk("bp_data", 32'(tx_data[0]), 32'h12);
         @(posedge clock); #1;
      end
      tx_ready = 1'b1;
      wait_finish(2, 1'b0, 1'b0);
      chk("bp_count", 32'(xfer_cnt[0] - b0), 32'd4);

      // Zero length with done held high
      res_base = 8'($urandom);
      res_len  = 8'd0;
      done     = 1'b1;
      @(posedge clock); #1;
      for (int n = 0; n < 11; n++) begin
         for (int i = 0; i < 2; i++) begin
            chk("zero_done", 32'(upload_done[i]), 32'd1);
            chk("zero_mem_sel", 32'(mem_sel[i]), 32'd0);
            chk("zero_valid", 32'(tx_valid[i]), 32'd0);
         end
         @(posedge clock); #1;
      end
      done = 1'b0;
      @(posedge clock); #1;
      check_zero("zero_idle");

      // Address wrap 0xFF -> 0x00
      mem[8'hFF] = 16'h0001;
      mem[8'h00] = 16'h0002;
      start(8'hFF, 8'd2, 1'b0);
      chk("wrap_addr", 32'(addr_data[1]), 32'hFF);
      wait_finish(2, 1'b0, 1'b1);

      // Reset after the third byte, then full restart with done still high
      base = 8'($urandom);
      b0 = xfer_cnt[0];
      start(base, 8'd4, 1'b0);
      c = 0;
      while ((xfer_cnt[0] - b0) < 3 && c < 200) begin
         @(posedge clock); #1;
         c++;
      end
      chk("rst_three_xfers", 32'(xfer_cnt[0] - b0), 32'd3);
      RST = 1'b1;
      @(posedge clock); #1;
      check_zero("midreset");
      RST      = 1'b0;
      res_base = base;
      res_len  = 8'd4;
      for (int i = 0; i < 2; i++) exp_q[i].delete();
      expect_push(base, 8'd4);
      wait_finish(4, 1'b0, 1'b1);

      // Randomized uploads: random data, base, length, ready pattern, done pulse vs hold
      for (int n = 0; n < 20; n++) begin
         base = 8'($urandom);
         len  = 8'($urandom_range(1, 6));
         for (int k = 0; k < int'(len); k++) mem[8'(int'(base) + k)] = 16'($urandom);
         rr = 1'($urandom_range(0, 1));
         pu = 1'($urandom_range(0, 1));
         tx_ready = 1'b1;
         start(base, len, pu);
         wait_finish(int'(len), rr, !rr);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
